// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state types, iteration count and result-selection helper for the mul/div unit
package mdu_pkg;
  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_t;
  typedef enum logic [1:0] {MDU_IDLE = 2'd0, MDU_BUSY = 2'd1, MDU_DONE = 2'd2} mdu_state_t;
  localparam int MDU_ITER = 32;
  // p is {hi,lo} for multiplies and {remainder,quotient} for divides
  function automatic logic [31:0] mdu_pick(mdu_op_t op, logic neg, logic [63:0] p);
    logic [63:0] n;
    n = neg ? -p : p;
    if (op[2]) return op[1] ? (neg ? -p[63:32] : p[63:32]) : (neg ? -p[31:0] : p[31:0]);
    return op == MDU_MUL ? n[31:0] : n[63:32];
  endfunction
endpackage

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: execute-stage <-> mul/div unit handshake and result bus
interface mdu_sequencer_if;
  logic        MulDivE;
  logic [2:0]  MDUOpE;
  logic [31:0] Op1E;
  logic [31:0] Op2E;
  logic        FlushE;
  logic        StallMDU;
  logic        MDUValidE;
  logic [31:0] MDUResultE;
  logic        MDUBusy;
  modport master (output MulDivE, MDUOpE, Op1E, Op2E, FlushE,
                  input  StallMDU, MDUValidE, MDUResultE, MDUBusy);
  modport slave  (input  MulDivE, MDUOpE, Op1E, Op2E, FlushE,
                  output StallMDU, MDUValidE, MDUResultE, MDUBusy);
endinterface

// File: rtl/mdu_datapath.sv
// mdu_datapath: radix-2 shift-add multiply / restoring divide step on unsigned magnitudes
module mdu_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] acc
);
  logic [31:0] mcd;
  logic [32:0] sum, r, diff;
  logic        nb;
  // acc low half holds the multiplier / dividend and fills with product / quotient bits
  always_comb begin
    sum  = {1'b0, acc[63:32]} + {1'b0, acc[0] ? mcd : 32'd0};
    r    = {acc[63:32], acc[31]};
    diff = r - {1'b0, mcd};
    nb   = r >= {1'b0, mcd};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      mcd <= '0;
    end else if (load) begin
      acc <= {32'd0, a};
      mcd <= b;
    end else if (step)
      acc <= is_div ? {nb ? diff[31:0] : r[31:0], acc[30:0], nb} : {sum, acc[31:1]};
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative mul/div controller stalling F/D/E until the result is ready.
// Define MDU_FAST_MUL_EN to compute multiplies in a single cycle.
module mdu_sequencer import mdu_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic rst,
  mdu_sequencer_if.slave mdu
);
  localparam logic [1:0] S_IDLE = MDU_IDLE;
  localparam logic [1:0] S_BUSY = MDU_BUSY;
  localparam logic [1:0] S_DONE = MDU_DONE;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MDU_ITER - 1);
  logic [1:0]      state;
  logic [CNT_W-1:0] cnt;
  mdu_op_t         op, op_in;
  logic            neg, neg_in, sa, sb, direct, div0, ovf, short, accept;
  logic [XLEN-1:0] dres, sres, abs_a, abs_b;
  logic [63:0]     acc;
  always_comb begin
    op_in  = mdu_op_t'(mdu.MDUOpE);
    sa     = mdu.Op1E[31] && (op_in == MDU_MULH || op_in == MDU_MULHSU || op_in == MDU_DIV || op_in == MDU_REM);
    sb     = mdu.Op2E[31] && (op_in == MDU_MULH || op_in == MDU_DIV || op_in == MDU_REM);
    neg_in = op_in == MDU_REM ? sa : sa ^ sb;
    abs_a  = sa ? -mdu.Op1E : mdu.Op1E;
    abs_b  = sb ? -mdu.Op2E : mdu.Op2E;
    div0   = op_in[2] && mdu.Op2E == '0;
    ovf    = (op_in == MDU_DIV || op_in == MDU_REM) && mdu.Op1E == 32'h8000_0000 && mdu.Op2E == 32'hFFFF_FFFF;
    sres   = div0 ? (op_in[1] ? mdu.Op1E : '1) : (op_in[1] ? '0 : 32'h8000_0000);
`ifdef MDU_FAST_MUL_EN
    short  = div0 || ovf || !op_in[2];
    sres   = op_in[2] ? sres : mdu_pick(op_in, neg_in, {32'd0, abs_a} * {32'd0, abs_b});
`else
    short  = div0 || ovf;
`endif
    accept = state == S_IDLE && mdu.MulDivE && !mdu.FlushE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op     <= MDU_MUL;
      neg    <= 1'b0;
      direct <= 1'b0;
      dres   <= '0;
    end else if (mdu.FlushE)
      state <= S_IDLE;
    else if (accept) begin
      op     <= op_in;
      neg    <= neg_in;
      direct <= short;
      dres   <= sres;
      cnt    <= '0;
      state  <= short ? S_DONE : S_BUSY;
    end else if (state == S_BUSY) begin
      cnt   <= cnt + 1'b1;
      state <= cnt == LAST ? S_DONE : S_BUSY;
    end else if (state == S_DONE)
      state <= S_IDLE;
  mdu_datapath u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (state == S_BUSY && !mdu.FlushE),
    .is_div (op[2]),
    .a      (abs_a),
    .b      (abs_b),
    .acc    (acc)
  );
  assign mdu.StallMDU   = !mdu.FlushE && (state == S_BUSY || (state == S_IDLE && mdu.MulDivE));
  assign mdu.MDUValidE  = state == S_DONE && !mdu.FlushE;
  assign mdu.MDUResultE = mdu.MDUValidE ? (direct ? dres : mdu_pick(op, neg, acc)) : '0;
  assign mdu.MDUBusy    = state != S_IDLE;
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed and random mul/div ops checked against an arithmetic reference model
module tb_mdu_sequencer;
  logic clk = 0;
  logic rst = 1;
  int   checks = 0;
  int   errors = 0;
  int   cycles = 0;
  int   t1, t2;
  mdu_sequencer_if m();
  mdu_sequencer dut (.clk(clk), .rst(rst), .mdu(m));
  always #5 clk = ~clk;
  always @(posedge clk) cycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic ov;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    ov = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (op)
      3'd0: p = ua * ub;
      3'd1: p = (sa * sb) >>> 32;
      3'd2: p = (sa * ub) >>> 32;
      3'd3: p = (ua * ub) >> 32;
      3'd4: p = b == 0 ? -1 : ov ? longint'(32'h8000_0000) : sa / sb;
      3'd5: p = b == 0 ? -1 : ua / ub;
      3'd6: p = b == 0 ? ua : ov ? 0 : sa % sb;
      default: p = b == 0 ? ua : ua % ub;
    endcase
    return p[31:0];
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      m.MulDivE = 0;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int t_valid);
    int cyc, stalls, occ;
    logic [31:0] exp;
    logic short_op;
    exp = model(op, a, b);
    short_op = op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MDU_FAST_MUL_EN
    short_op = short_op || !op[2];
`endif
    occ = short_op ? 2 : 34;
    @(negedge clk);
    m.MulDivE = 1;
    m.MDUOpE = op;
    m.Op1E = a;
    m.Op2E = b;
    cyc = 0;
    stalls = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (m.MDUValidE) break;
      stalls += int'(m.StallMDU);
      cyc++;
      @(negedge clk);
      m.Op1E = $urandom;
      m.Op2E = $urandom;
    end
    t_valid = cycles;
    check($sformatf("valid op%0d", op), {31'd0, m.MDUValidE}, 32'd1);
    check($sformatf("result op%0d %h %h", op, a, b), m.MDUResultE, exp);
    check($sformatf("stall_at_valid op%0d", op), {31'd0, m.StallMDU}, 32'd0);
    check($sformatf("occupancy op%0d", op), 32'(cyc + 1), 32'(occ));
    check($sformatf("stall_cycles op%0d", op), 32'(stalls), 32'(occ - 1));
  endtask

  initial begin
    int t, sel, vcount;
    logic [2:0] op;
    logic [31:0] a, b;
    m.MulDivE = 0;
    m.MDUOpE = 0;
    m.Op1E = 0;
    m.Op2E = 0;
    m.FlushE = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_stall", {31'd0, m.StallMDU}, 32'd0);
    check("reset_valid", {31'd0, m.MDUValidE}, 32'd0);
    check("reset_busy", {31'd0, m.MDUBusy}, 32'd0);
    check("reset_result", m.MDUResultE, 32'd0);
    @(negedge clk);
    rst = 0;
    idle(2);
    run_op(3'd0, 32'h7, 32'hFFFF_FFFD, t);
    check("mul_7x-3", m.MDUResultE, 32'hFFFF_FFEB);
    idle(1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, t);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, t);
    run_op(3'd5, 32'd100, 32'd7, t);
    run_op(3'd7, 32'd100, 32'd7, t);
    run_op(3'd4, 32'd5, 32'd0, t);
    run_op(3'd6, 32'd5, 32'd0, t);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, t);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, t);
    idle(2);
    // flush while BUSY at cnt=10, then confirm no stray valid pulse
    @(negedge clk);
    m.MulDivE = 1;
    m.MDUOpE = 3'd0;
    m.Op1E = 32'd9;
    m.Op2E = 32'd9;
    repeat (11) @(negedge clk);
    m.FlushE = 1;
    #1;
    check("flush_stall", {31'd0, m.StallMDU}, 32'd0);
    check("flush_valid", {31'd0, m.MDUValidE}, 32'd0);
    @(negedge clk);
    m.FlushE = 0;
    m.MulDivE = 0;
    #1;
    check("flush_busy", {31'd0, m.MDUBusy}, 32'd0);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      vcount += int'(m.MDUValidE);
    end
    check("flush_no_pulse", 32'(vcount), 32'd0);
    run_op(3'd0, 32'd3, 32'd4, t);
    idle(1);
    run_op(3'd0, 32'd2, 32'd3, t1);
    run_op(3'd0, 32'd5, 32'd5, t2);
`ifdef MDU_FAST_MUL_EN
    check("b2b_spacing", 32'(t2 - t1), 32'd2);
`else
    check("b2b_spacing", 32'(t2 - t1), 32'd34);
`endif
    idle(1);
    // reset at cnt=20 must clear outputs immediately
    @(negedge clk);
    m.MulDivE = 1;
    m.MDUOpE = 3'd5;
    m.Op1E = 32'd1000;
    m.Op2E = 32'd3;
    repeat (21) @(negedge clk);
    m.MulDivE = 0;
    rst = 1;
    #1;
    check("rst_busy", {31'd0, m.MDUBusy}, 32'd0);
    check("rst_stall", {31'd0, m.StallMDU}, 32'd0);
    check("rst_valid", {31'd0, m.MDUValidE}, 32'd0);
    check("rst_result", m.MDUResultE, 32'd0);
    @(negedge clk);
    rst = 0;
    idle(1);
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      a = $urandom;
      b = sel == 2 ? 32'($urandom_range(1, 15)) : $urandom;
      if (sel == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if (sel == 1) b = 0;
      run_op(op, a, b, t);
      if (sel > 5) idle(1);
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
